// File: rtl/mips_data_bus_responder_pkg.sv
// Shared data-bus definitions: MMIO map, register offsets,
// status/control bit positions and the MMIO offset decoder.
package mips_data_bus_responder_pkg;

  localparam logic [31:0] MMIO_BASE = 32'hFFFF_0000;

  localparam logic [15:0] OFF_CONS_DATA  = 16'h0000;
  localparam logic [15:0] OFF_CONS_STAT  = 16'h0004;
  localparam logic [15:0] OFF_TIMER_CNT  = 16'h0008;
  localparam logic [15:0] OFF_TIMER_CMP  = 16'h000C;
  localparam logic [15:0] OFF_TIMER_CTRL = 16'h0010;

  localparam int STAT_EMPTY = 0;
  localparam int STAT_FULL  = 1;
  localparam int STAT_OVF   = 2;
  localparam int STAT_BERR  = 3;

  localparam int CTRL_EN  = 0;
  localparam int CTRL_IRQ = 1;

  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_RAM,
    SEL_CDATA,
    SEL_CSTAT,
    SEL_TCNT,
    SEL_TCMP,
    SEL_TCTRL
  } sel_e;

  function automatic sel_e mmio_sel(logic [15:0] off);
    sel_e s;
    case (off)
      OFF_CONS_DATA:  s = SEL_CDATA;
      OFF_CONS_STAT:  s = SEL_CSTAT;
      OFF_TIMER_CNT:  s = SEL_TCNT;
      OFF_TIMER_CMP:  s = SEL_TCMP;
      OFF_TIMER_CTRL: s = SEL_TCTRL;
      default:        s = SEL_NONE;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/mips_data_bus_responder_fifo.sv
// Console TX byte FIFO: power-of-2 depth, push accepted
// when full only if a pop frees a slot in the same cycle.
module mips_resp_fifo #(
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [7:0]    din,
  output logic [7:0]    dout,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count
);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = empty ? 8'h00 : mem[rd_ptr];

  // Storage array, written at the tail on an accepted push
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointers and occupancy; pointers wrap at the power-of-2 depth
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mips_data_bus_responder.sv
// Data-memory responder for the single-cycle core: word RAM,
// console FIFO and timer, with same-cycle read data.
module mips_data_bus_responder
  import mips_data_bus_responder_pkg::*;
#(
  parameter int RAM_AW     = 10,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_ren,
  input  logic        mem_wen,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_dout,
  output logic [31:0] mem_din,
  output logic        cons_valid,
  output logic [7:0]  cons_data,
  input  logic        cons_ready,
  output logic        timer_irq,
  output logic        bus_err
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [31:0]       ram [2**RAM_AW];
  logic [RAM_AW-1:0] widx;
  sel_e              sel;
  logic              err;
  logic              rd;
  logic              wr;
  logic              ram_we;
  logic              push;
  logic              pop;
  logic              f_full;
  logic              f_empty;
  logic [CW-1:0]     f_count;
  logic              stat_empty;
  logic              overflow;
  logic [31:0]       cnt;
  logic [31:0]       cmp;
  logic              en;
  logic              irq;
  logic              match;

  assign widx = mem_addr[RAM_AW+1:2];

  // Address decode; errors drop the access entirely
  always_comb begin
    sel = SEL_NONE;
    if (mem_addr[31:RAM_AW+2] == '0)
      sel = SEL_RAM;
    else if (mem_addr[31:16] == MMIO_BASE[31:16])
      sel = mmio_sel(mem_addr[15:0]);
    err = (mem_ren || mem_wen) &&
          ((mem_addr[1:0] != 2'b00) ||
           (sel == SEL_NONE) ||
           (mem_ren && mem_wen));
    rd  = mem_ren && !err;
    wr  = mem_wen && !err;
  end

  assign ram_we     = wr && (sel == SEL_RAM) && !rst;
  assign push       = wr && (sel == SEL_CDATA);
  assign pop        = cons_valid && cons_ready;
  assign cons_valid = !f_empty;
  assign stat_empty = (f_count == '0);
  assign match      = en && (cnt == cmp);
  assign timer_irq  = irq;

  mips_resp_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (mem_dout[7:0]),
    .dout  (cons_data),
    .full  (f_full),
    .empty (f_empty),
    .count (f_count)
  );

  // Word RAM write port
  always_ff @(posedge clk) begin
    if (ram_we) ram[widx] <= mem_dout;
  end

  // Same-cycle read mux from current state
  always_comb begin
    mem_din = 32'h0;
    if (rd) begin
      case (sel)
        SEL_RAM:   mem_din = ram[widx];
        SEL_CSTAT: mem_din = {28'h0, bus_err, overflow,
                              f_full, stat_empty};
        SEL_TCNT:  mem_din = cnt;
        SEL_TCMP:  mem_din = cmp;
        SEL_TCTRL: mem_din = {30'h0, irq, en};
        default:   mem_din = 32'h0;
      endcase
    end
  end

  // Sticky error/overflow flags; a new error beats the STAT clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus_err  <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (rd && sel == SEL_CSTAT) begin
        bus_err  <= 1'b0;
        overflow <= 1'b0;
      end
      if (push && f_full && !pop) overflow <= 1'b1;
      if (err) bus_err <= 1'b1;
    end
  end

  // Timer; CNT write beats count/reload, match beats W1C
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      cmp <= '0;
      en  <= 1'b0;
      irq <= 1'b0;
    end else begin
      if (en) cnt <= match ? 32'h0 : cnt + 32'd1;
      if (wr && sel == SEL_TCTRL) begin
        en <= mem_dout[CTRL_EN];
        if (mem_dout[CTRL_IRQ]) irq <= 1'b0;
      end
      if (match) irq <= 1'b1;
      if (wr && sel == SEL_TCMP) cmp <= mem_dout;
      if (wr && sel == SEL_TCNT) cnt <= mem_dout;
    end
  end

endmodule
